// File: rtl/inst_enc_pkg.sv
// rtl/inst_enc_pkg.sv - shared formats, states and opcodes for the instruction encode loader
package inst_enc_pkg;

    // Values line up with the decode-side ImmSel encoding so host tools share one table.
    typedef enum logic [2:0] {
        FMT_I   = 3'd0,
        FMT_IL  = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_J   = 3'd4,
        FMT_U   = 3'd5,
        FMT_R   = 3'd6,
        FMT_RSV = 3'd7
    } fmt_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;

    // True when v is the sign extension of its low 'bits' bits.
    function automatic logic fits_signed(input logic [31:0] v, input int bits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i >= bits - 1 && v[i] != v[31]) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/inst_encode_loader_if.sv
// rtl/inst_encode_loader_if.sv - field-beat handshake between host stream and encode loader
interface inst_encode_loader_if;

    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;

    modport master (
        output in_valid, in_last, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_last, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm,
        output in_ready
    );

endinterface

// File: rtl/inst_encode_loader_imm_pack.sv
// rtl/inst_encode_loader_imm_pack.sv - combinational field/immediate packer with range check
module imm_pack
    import inst_enc_pkg::*;
(
    input  fmt_e        fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (fmt)
            FMT_I, FMT_IL: begin
                word  = {imm[11:0], rs1, funct3, rd, opcode};
                legal = fits_signed(imm, 12);
            end
            FMT_S: begin
                word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                legal = fits_signed(imm, 12);
            end
            FMT_B: begin
                word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                legal = fits_signed(imm, 13) && !imm[0];
            end
            FMT_J: begin
                word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                legal = fits_signed(imm, 21) && !imm[0];
            end
            FMT_U: begin
                word  = {imm[31:12], rd, opcode};
                legal = (imm[11:0] == 12'h000);
            end
            FMT_R: begin
                word  = {funct7, rs2, rs1, funct3, rd, opcode};
                legal = 1'b1;
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/inst_encode_loader.sv
// rtl/inst_encode_loader.sv - encodes field beats into RISC-V words and writes instruction memory
module inst_encode_loader
    import inst_enc_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    inst_encode_loader_if.slave bus,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [31:0]         mem_wdata,
    output logic                busy,
    output logic                done,
    output logic                err_imm,
    output logic [7:0]          err_cnt,
    output logic [ADDR_W:0]     wr_count
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

    state_e            state;
    logic [ADDR_W-1:0] wptr;
    logic [31:0]       word;
    logic              legal;

    imm_pack u_pack (
        .fmt    (fmt_e'(bus.in_fmt)),
        .opcode (bus.in_opcode),
        .rd     (bus.in_rd),
        .rs1    (bus.in_rs1),
        .rs2    (bus.in_rs2),
        .funct3 (bus.in_funct3),
        .funct7 (bus.in_funct7),
        .imm    (bus.in_imm),
        .word   (word),
        .legal  (legal)
    );

    assign bus.in_ready = (state == LOAD);
    assign busy         = (state == LOAD);
    assign done         = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wptr      <= BASE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err_imm   <= 1'b0;
            err_cnt   <= '0;
            wr_count  <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= LOAD;
                        wptr     <= BASE;
                        wr_count <= '0;
                        err_imm  <= 1'b0;
                        err_cnt  <= '0;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        if (legal) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= wptr;
                            mem_wdata <= word;
                            wptr      <= wptr + 1'b1;
                            wr_count  <= wr_count + 1'b1;
                        end else begin
                            err_imm <= 1'b1;
                            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
                        end
                        // Stop on the last beat, or once the memory holds DEPTH words.
                        if (bus.in_last || (legal && wr_count == LAST_CNT)) state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_encode_loader.sv
// tb/tb_inst_encode_loader.sv - randomized self-checking bench with a behavioural loader model
module tb_inst_encode_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic        last = 1'b0;
    logic [2:0]  fmt = '0;
    logic [6:0]  op = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [2:0]  f3 = '0;
    logic [6:0]  f7 = '0;
    logic [31:0] imm = '0;

    logic        mem_we0, busy0, done0, err_imm0;
    logic [9:0]  mem_addr0;
    logic [31:0] mem_wdata0;
    logic [7:0]  err_cnt0;
    logic [10:0] wr_count0;
    logic        mem_we1, busy1, done1, err_imm1;
    logic [1:0]  mem_addr1;
    logic [31:0] mem_wdata1;
    logic [7:0]  err_cnt1;
    logic [2:0]  wr_count1;

    int n_checks = 0;
    int n_fail = 0;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_DONE = 2;
    int          depth [2] = '{1024, 4};
    int          m_mode [2];
    int          m_wr [2];
    int          m_cnt [2];
    int          m_addr [2];
    bit          m_err [2];
    bit          m_we [2];
    logic [31:0] m_wdata [2];

    always #5 clk = ~clk;

    inst_encode_loader_if bus0 ();
    inst_encode_loader_if bus1 ();

    assign bus0.in_valid = valid;   assign bus1.in_valid = valid;
    assign bus0.in_last = last;     assign bus1.in_last = last;
    assign bus0.in_fmt = fmt;       assign bus1.in_fmt = fmt;
    assign bus0.in_opcode = op;     assign bus1.in_opcode = op;
    assign bus0.in_rd = rd;         assign bus1.in_rd = rd;
    assign bus0.in_rs1 = rs1;       assign bus1.in_rs1 = rs1;
    assign bus0.in_rs2 = rs2;       assign bus1.in_rs2 = rs2;
    assign bus0.in_funct3 = f3;     assign bus1.in_funct3 = f3;
    assign bus0.in_funct7 = f7;     assign bus1.in_funct7 = f7;
    assign bus0.in_imm = imm;       assign bus1.in_imm = imm;

    inst_encode_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut_big (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus0),
        .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .busy(busy0), .done(done0), .err_imm(err_imm0), .err_cnt(err_cnt0),
        .wr_count(wr_count0)
    );

    inst_encode_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus1),
        .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .busy(busy1), .done(done1), .err_imm(err_imm1), .err_cnt(err_cnt1),
        .wr_count(wr_count1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit legal_m(input int f, input logic [31:0] v);
        int s;
        s = $signed(v);
        case (f)
            0, 1, 2: return (s >= -2048) && (s <= 2047);
            3:       return (s >= -4096) && (s <= 4095) && (s % 2 == 0);
            4:       return (s >= -1048576) && (s <= 1048575) && (s % 2 == 0);
            5:       return (v % 4096) == 0;
            6:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] enc_m(input int f, input logic [31:0] o, d, a, b,
                                          input logic [31:0] fn3, fn7, v);
        logic [31:0] regs;
        regs = (b << 20) | (a << 15) | (fn3 << 12);
        case (f)
            0, 1: return ((v & 32'hFFF) << 20) | (a << 15) | (fn3 << 12) | (d << 7) | o;
            2:    return (((v >> 5) & 32'h7F) << 25) | regs | ((v & 32'h1F) << 7) | o;
            3:    return (((v >> 12) & 1) << 31) | (((v >> 5) & 32'h3F) << 25) | regs
                         | (((v >> 1) & 32'hF) << 8) | (((v >> 11) & 1) << 7) | o;
            4:    return (((v >> 20) & 1) << 31) | (((v >> 1) & 32'h3FF) << 21)
                         | (((v >> 11) & 1) << 20) | (((v >> 12) & 32'hFF) << 12) | (d << 7) | o;
            5:    return (v & 32'hFFFFF000) | (d << 7) | o;
            default: return (fn7 << 25) | regs | (d << 7) | o;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = M_IDLE; m_wr[k] = 0; m_cnt[k] = 0; m_err[k] = 1'b0; m_we[k] = 1'b0;
        end
    endtask

    task automatic model_edge(input int k);
        m_we[k] = 1'b0;
        if (m_mode[k] == M_LOAD) begin
            if (valid) begin
                if (legal_m(int'(fmt), imm)) begin
                    m_we[k]    = 1'b1;
                    m_addr[k]  = m_wr[k] % depth[k];
                    m_wdata[k] = enc_m(int'(fmt), 32'(op), 32'(rd), 32'(rs1), 32'(rs2),
                                       32'(f3), 32'(f7), imm);
                    m_wr[k]++;
                    if (m_wr[k] == depth[k]) m_mode[k] = M_DONE;
                end else begin
                    m_err[k] = 1'b1;
                    if (m_cnt[k] < 255) m_cnt[k]++;
                end
                if (last) m_mode[k] = M_DONE;
            end
        end else if (start) begin
            m_mode[k] = M_LOAD; m_wr[k] = 0; m_cnt[k] = 0; m_err[k] = 1'b0;
        end
    endtask

    task automatic check_inst(input int k, input logic rdy, we, input logic [31:0] addr, wdata,
                              input logic bsy, dn, ei, input logic [7:0] ec, input logic [31:0] wc);
        string p;
        p = (k == 0) ? "big" : "small";
        check_eq({p, "_in_ready"}, 32'(rdy), 32'(m_mode[k] == M_LOAD));
        check_eq({p, "_mem_we"}, 32'(we), 32'(m_we[k]));
        if (m_we[k]) begin
            check_eq({p, "_mem_addr"}, addr, 32'(m_addr[k]));
            check_eq({p, "_mem_wdata"}, wdata, m_wdata[k]);
        end
        check_eq({p, "_busy"}, 32'(bsy), 32'(m_mode[k] == M_LOAD));
        check_eq({p, "_done"}, 32'(dn), 32'(m_mode[k] == M_DONE));
        check_eq({p, "_err_imm"}, 32'(ei), 32'(m_err[k]));
        check_eq({p, "_err_cnt"}, 32'(ec), 32'(m_cnt[k]));
        check_eq({p, "_wr_count"}, wc, 32'(m_wr[k]));
    endtask

    task automatic check_all();
        check_inst(0, bus0.in_ready, mem_we0, 32'(mem_addr0), mem_wdata0, busy0, done0,
                   err_imm0, err_cnt0, 32'(wr_count0));
        check_inst(1, bus1.in_ready, mem_we1, 32'(mem_addr1), mem_wdata1, busy1, done1,
                   err_imm1, err_cnt1, 32'(wr_count1));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        check_all();
    endtask

    task automatic beat(input logic [2:0] f, input logic [6:0] o, input logic [4:0] d, a, b,
                        input logic [2:0] fn3, input logic [31:0] v, input logic l);
        valid = 1'b1; fmt = f; op = o; rd = d; rs1 = a; rs2 = b; f3 = fn3; f7 = '0;
        imm = v; last = l;
    endtask

    task automatic idle();
        valid = 1'b0; last = 1'b0; start = 1'b0;
    endtask

    task automatic pulse_start();
        idle(); start = 1'b1; step(); start = 1'b0;
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] r;
        case ($urandom_range(0, 3))
            0:       r = $urandom;
            1:       r = 32'(int'($urandom_range(0, 12000)) - 6000);
            2:       r = 32'(int'($urandom_range(0, 2400000)) - 1200000);
            default: r = $urandom & 32'hFFFFF000;
        endcase
        if ($urandom_range(0, 1) == 1) r[0] = 1'b0;
        return r;
    endfunction

    task automatic rand_beat(input logic l);
        valid = ($urandom_range(0, 4) != 0);
        fmt = 3'($urandom_range(0, 7)); op = 7'($urandom); rd = 5'($urandom);
        rs1 = 5'($urandom); rs2 = 5'($urandom); f3 = 3'($urandom); f7 = 7'($urandom);
        imm = rand_imm();
        last = l;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Directed program: I, S, B, J, U with last
        pulse_start();
        beat(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 1'b0); step();
        check_eq("t1_wdata", mem_wdata0, 32'h00500093);
        check_eq("t1_addr", 32'(mem_addr0), 32'd0);
        check_eq("t1_wr_count", 32'(wr_count0), 32'd1);
        beat(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8, 1'b0); step();
        check_eq("t2_s_wdata", mem_wdata0, 32'h0020A423);
        beat(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFC, 1'b0); step();
        check_eq("t2_b_wdata", mem_wdata0, 32'hFE000EE3);
        check_eq("t2_b_addr", 32'(mem_addr0), 32'd2);
        beat(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 1'b0); step();
        check_eq("t3_j_wdata", mem_wdata0, 32'h001000EF);
        beat(3'd5, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000, 1'b1); step();
        check_eq("t3_u_wdata", mem_wdata0, 32'h123452B7);
        check_eq("t3_done", 32'(done0), 32'd1);
        check_eq("t3_in_ready", 32'(bus0.in_ready), 32'd0);
        idle(); step();

        // Illegal immediates are dropped and counted
        pulse_start();
        beat(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 1'b0); step();
        beat(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd7, 1'b0); step();
        beat(3'd5, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 32'h00001001, 1'b0); step();
        idle(); step();
        check_eq("t4_err_imm", 32'(err_imm0), 32'd1);
        check_eq("t4_err_cnt", 32'(err_cnt0), 32'd3);
        check_eq("t4_wr_count", 32'(wr_count0), 32'd0);
        beat(3'd7, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 1'b1); step();

        // Fill the 4-word memory with valid held high
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            beat(3'd0, 7'h13, 5'(i + 1), 5'd2, 5'd0, 3'd0, 32'(i * 3), 1'b0); step();
        end
        idle(); step();
        check_eq("t5_small_wr_count", 32'(wr_count1), 32'd4);
        check_eq("t5_small_done", 32'(done1), 32'd1);
        beat(3'd6, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 32'd0, 1'b1); step();

        // Asynchronous reset right after an accepted beat
        pulse_start();
        beat(3'd0, 7'h13, 5'd4, 5'd4, 5'd0, 3'd0, 32'd100, 1'b0); step();
        idle();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("t6_we_async_big", 32'(mem_we0), 32'd0);
        check_eq("t6_we_async_small", 32'(mem_we1), 32'd0);
        check_all();
        #2 rst_n = 1'b1;
        step();
        step();

        // Random sessions, with stray start pulses during LOAD
        for (int s = 0; s < 40; s++) begin
            pulse_start();
            for (int c = 0; c < 40; c++) begin
                rand_beat($urandom_range(0, 11) == 0);
                start = ($urandom_range(0, 15) == 0);
                step();
                start = 1'b0;
                if (m_mode[0] != M_LOAD && m_mode[1] != M_LOAD) break;
            end
            rand_beat(1'b1);
            valid = 1'b1;
            step();
            idle(); step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_encode_loader.md
Name: inst_encode_loader

Overview:
- Inverse of the immediate decode path: takes decoded instruction fields plus a 32-bit immediate, packs the immediate into the RISC-V bit positions for the selected format, and writes the assembled word into instruction memory.
- Sits between a host/UART field stream and the instruction-memory write port on the DE1-SoC.
- Lets programs be loaded without an offline assembler.
- Includes a valid/ready input handshake, a registered write stage, an address counter, and immediate range checking.

Parameters:
- ADDR_W, 10, instruction-memory word-address width; DEPTH = 2**ADDR_W.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- start  in  1  pulse; begin a load session
- in_valid  in  1  field beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready at posedge clk
- in_last  in  1  final beat of session
- in_fmt  in  3  0/1=I, 2=S, 3=B, 4=J, 5=U, 6=R (no immediate), 7=reserved
- in_opcode  in  7  opcode
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3
- in_funct7  in  7  used only for fmt 6
- in_imm  in  32  immediate value, full byte offset for B/J
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  32  encoded instruction
- busy  out  1  state==LOAD
- done  out  1  state==DONE
- err_imm  out  1  sticky; an illegal beat was dropped
- err_cnt  out  8  illegal beats dropped, saturating at 255
- wr_count  out  ADDR_W+1  legal words written this session

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; all outputs 0; write pointer=BASE_ADDR.
- Reset mid-operation: any pending write is dropped (mem_we=0 immediately) and all counters and flags clear.
- States:
  - IDLE: start -> LOAD; clear wr_count, err_imm, err_cnt; pointer=BASE_ADDR.
  - LOAD: in_ready=1. start is ignored.
  - DONE: in_ready=0. start -> LOAD with the same clears as from IDLE.
- LOAD -> DONE on the edge that accepts a beat with in_last=1, or the edge that accepts the legal beat making wr_count==DEPTH.
  - The memory is then full; the counter does not wrap.
  - in_ready drops in the cycle after that edge.
- Latency: a legal beat accepted at edge N gives mem_we=1 for exactly one cycle after edge N, with mem_addr/mem_wdata registered. The pointer and wr_count increment at the same edge N. Throughput is one beat per cycle.
- Encoding, with rd at [11:7] and opcode at [6:0] where the format has them:
  - I: imm[11:0]->[31:20], rs1, funct3, rd, opcode.
  - S: imm[11:5]->[31:25], imm[4:0]->[11:7].
  - B: imm[12]->[31], imm[10:5]->[30:25], imm[4:1]->[11:8], imm[11]->[7].
  - J: imm[20]->[31], imm[10:1]->[30:21], imm[11]->[20], imm[19:12]->[19:12].
  - U: imm[31:12]->[31:12].
  - R: funct7, rs2, rs1, funct3, rd, opcode.
- Legality checks (failure = illegal):
  - I/S: in_imm sign-extends from 12 bits.
  - B: sign-extends from 13 bits and in_imm[0]=0.
  - J: sign-extends from 21 bits and in_imm[0]=0.
  - U: in_imm[11:0]=0.
  - fmt 7: always illegal.
- Illegal beat handling: the beat is consumed; no write; pointer and wr_count unchanged; err_imm set; err_cnt increments, saturating at 255.
- An illegal beat with in_last=1 still moves LOAD -> DONE.
- in_valid=0 in LOAD means no state change.

Decomposition:
- Package inst_enc_pkg:
  - fmt_e enum (FMT_I, FMT_IL, FMT_S, FMT_B, FMT_J, FMT_U, FMT_R, FMT_RSV) with values matching the decode-side ImmSel encoding.
  - state_e (IDLE, LOAD, DONE).
  - opcode constants (OP_IMM 7'h13, LOAD 7'h03, STORE 7'h23, BRANCH 7'h63, JAL 7'h6F, LUI 7'h37, AUIPC 7'h17).
- Sub-module imm_pack: purely combinational. Takes fields + in_imm + fmt and produces the 32-bit word and a legal flag. The top holds the FSM, handshake, pointer and registered write stage.

Test Plan:
1. start; beat fmt0 opc 0x13 rd1 rs1 0 f3 0 imm 5, last=0 -> next cycle mem_we=1, addr=0, wdata=0x00500093, wr_count=1.
2. fmt2 opc 0x23 rs1 1 rs2 2 f3 2 imm 8 -> 0x0020A423. Then fmt3 opc 0x63 rs1=rs2=0 imm -4 -> 0xFE000EE3 at addr 2.
3. fmt4 opc 0x6F rd1 imm 2048 -> 0x001000EF. Then fmt5 opc 0x37 rd5 imm 0x12345000 with last=1 -> 0x123452B7; done=1 and in_ready=0 the next cycle.
4. fmt0 imm 2048, then fmt3 imm 6 (odd-free but out of none? use imm 7), then fmt5 imm 0x1001 -> no mem_we for any; err_imm=1, err_cnt=3, wr_count unchanged.
5. ADDR_W=2: 5 legal beats back-to-back with in_valid held -> writes to addr 0..3, DONE after the 4th, 5th beat not accepted, wr_count=4.
6. Assert rst_n low the cycle after a beat is accepted -> mem_we=0 asynchronously; outputs 0; state IDLE; in_ready=0 until the next start.
